// File: rtl/sha256_padder_if.sv
// Byte-stream input and 512-bit block output bundle for the SHA-256 padder.
// The master side drives the bytes; the slave side is the padder itself.
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic [511:0] block_out;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input  in_ready, block_out, blk_valid, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, block_out, blk_valid, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a byte stream into 512-bit blocks and
// appends 0x80, zero fill and the 64-bit big-endian bit length.
module sha256_padder (
  input  logic            clk,
  input  logic            rst_n,
  sha256_padder_if.slave  bus
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  localparam logic [1:0] TAIL_NONE = 2'd0;
  localparam logic [1:0] TAIL_LEN  = 2'd1;
  localparam logic [1:0] TAIL_FULL = 2'd2;

  logic [1:0]   r_state;
  logic [5:0]   r_ptr;
  logic [63:0]  r_len;
  logic [511:0] r_block;
  logic         r_first_pend;
  logic         r_last;
  logic         r_full;
  logic [1:0]   r_tail;

  logic         w_take;
  logic         w_data;
  logic         w_hs;
  logic [8:0]   w_wr_msb;

  assign w_take   = bus.in_valid & (r_state == S_FILL);
  // an empty terminator ends the message without contributing a byte
  assign w_data   = w_take & ~(bus.in_last & bus.in_empty);
  assign w_hs     = (r_state == S_EMIT) & bus.blk_ready;
  assign w_wr_msb = 9'd511 - {r_ptr, 3'b000};

  assign bus.in_ready  = (r_state == S_FILL);
  assign bus.blk_valid = (r_state == S_EMIT);
  assign bus.blk_first = (r_state == S_EMIT) & r_first_pend;
  assign bus.blk_last  = (r_state == S_EMIT) & r_last;
  assign bus.block_out = r_block;

  // Padder state machine: byte packing, padding, emission and tail block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_ptr        <= 6'd0;
      r_len        <= 64'd0;
      r_block      <= 512'd0;
      r_first_pend <= 1'b1;
      r_last       <= 1'b0;
      r_full       <= 1'b0;
      r_tail       <= TAIL_NONE;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_data) begin
            r_block[w_wr_msb -: 8] <= bus.in_data;
            r_ptr                  <= r_ptr + 6'd1;
            r_len                  <= r_len + 64'd8;
          end
          if (w_take && bus.in_last) begin
            r_full  <= w_data & (r_ptr == 6'd63);
            r_state <= S_PAD;
          end else if (w_data && (r_ptr == 6'd63)) begin
            r_last  <= 1'b0;
            r_state <= S_EMIT;
          end else begin
            r_state <= S_FILL;
          end
        end
        S_PAD: begin
          if (r_full) begin
            r_tail <= TAIL_FULL;
            r_last <= 1'b0;
          end else if (r_ptr <= 6'd55) begin
            r_block[w_wr_msb -: 8] <= 8'h80;
            r_block[63:0]          <= r_len;
            r_last                 <= 1'b1;
          end else begin
            r_block[w_wr_msb -: 8] <= 8'h80;
            r_tail                 <= TAIL_LEN;
            r_last                 <= 1'b0;
          end
          r_full  <= 1'b0;
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (w_hs) begin
            r_block      <= 512'd0;
            r_ptr        <= 6'd0;
            r_first_pend <= 1'b0;
            if (r_tail != TAIL_NONE) begin
              r_state <= S_TAIL;
            end else begin
              if (r_last) begin
                r_len        <= 64'd0;
                r_first_pend <= 1'b1;
              end
              r_state <= S_FILL;
            end
          end
        end
        S_TAIL: begin
          r_block <= {((r_tail == TAIL_FULL) ? 8'h80 : 8'h00), 440'd0, r_len};
          r_tail  <= TAIL_NONE;
          r_last  <= 1'b1;
          r_state <= S_EMIT;
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized scoreboard bench for sha256_padder: a padding model feeds an
// expected-block queue that an independent output monitor drains.
module tb_sha256_padder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_padder_if bus();

  sha256_padder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   bp_hold = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic bq_t seq(input int n, input int start);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(start + i));
    return q;
  endfunction

  // Reference: padded byte string = msg, 0x80, zeros to 56 mod 64, 64-bit length
  task automatic push_model(input bq_t msg);
    bq_t          p;
    logic [63:0]  bits;
    int           nblk;
    exp_t         e;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = 512'd0;
      for (int j = 0; j < 64; j++) e.blk[511 - 8*j -: 8] = p[b*64 + j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // mode 0: data-carrying last beat, 1: empty terminator, 2: no terminator
  task automatic send_msg(input bq_t msg, input int mode);
    int   nb;
    int   cnt;
    logic exp_v;
    nb    = (mode == 1) ? msg.size() + 1 : msg.size();
    exp_v = 1'b0;
    if (mode != 2) push_model(msg);
    @(posedge clk); #1;
    for (int b = 0; b < nb; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (b < msg.size()) ? msg[b] : 8'($urandom);
      bus.in_last  = (mode != 2) && (b == nb - 1);
      bus.in_empty = (mode == 1) && (b == nb - 1);
      @(negedge clk);
      if (b > 0) check("byte_lat", 512'(bus.blk_valid), 512'(exp_v));
      cnt = 0;
      while (!bus.in_ready && cnt < 3000) begin
        @(negedge clk);
        cnt++;
      end
      if (!bus.in_ready) begin
        fail_now("in_ready_wait");
        bus.in_valid = 1'b0;
        return;
      end
      exp_v = ((b % 64) == 63) && !bus.in_last && (b < msg.size());
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    @(negedge clk);
    if (mode != 2) begin
      check("pad_gap", 512'(bus.blk_valid), 512'd0);
      @(negedge clk);
      check("blk_lat", 512'(bus.blk_valid), 512'd1);
    end else if (nb > 0) begin
      check("byte_lat", 512'(bus.blk_valid), 512'(exp_v));
    end
  endtask

  // Downstream ready: random, or forced low while bp_hold counts down
  initial begin
    bus.blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_hold > 0) begin
        bus.blk_ready = 1'b0;
        bp_hold--;
      end else begin
        bus.blk_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compares each handshaken block and checks stability under stall
  initial begin
    logic         stall;
    logic [511:0] p_blk;
    logic         p_first, p_last;
    exp_t         e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else if (bus.blk_valid) begin
        check("in_ready_emit", 512'(bus.in_ready), 512'd0);
        if (stall) begin
          check("stall_block", bus.block_out, p_blk);
          check("stall_first", 512'(bus.blk_first), 512'(p_first));
          check("stall_last", 512'(bus.blk_last), 512'(p_last));
        end
        if (bus.blk_ready) begin
          stall = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_block: got %0h, expected none", bus.block_out);
          end else begin
            e = exp_q.pop_front();
            check("block", bus.block_out, e.blk);
            check("first", 512'(bus.blk_first), 512'(e.first));
            check("last", 512'(bus.blk_last), 512'(e.last));
          end
        end else begin
          stall   = 1'b1;
          p_blk   = bus.block_out;
          p_first = bus.blk_first;
          p_last  = bus.blk_last;
        end
      end else begin
        if (stall) check("valid_dropped", 512'(bus.blk_valid), 512'd1);
        stall = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_valid", 512'(bus.blk_valid), 512'd0);
    check("rst_first", 512'(bus.blk_first), 512'd0);
    check("rst_last", 512'(bus.blk_last), 512'd0);
    check("rst_block", bus.block_out, 512'd0);
    check("rst_in_ready", 512'(bus.in_ready), 512'd1);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) fail_now("drain");
  endtask

  initial begin
    bq_t abc;
    int  n;
    abc = '{8'h61, 8'h62, 8'h63};
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_msg(abc, 0);
    drain();
    send_msg(seq(0, 0), 1);
    send_msg(seq(56, 0), 0);
    send_msg(seq(64, 0), 0);
    send_msg(seq(55, 8'h10), 1);
    send_msg(seq(63, 8'h20), 0);
    drain();

    bp_hold = 20;
    send_msg(abc, 0);
    send_msg(abc, 0);
    drain();

    send_msg(seq(30, 8'h40), 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_msg(abc, 0);
    drain();

    for (int k = 0; k < 25; k++) begin
      bq_t m;
      n = $urandom_range(0, 140);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(m, (n == 0) ? 1 : int'($urandom_range(0, 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
